seq_onehot_decoder: RTL



---
 rtl/seq_decoder_pkg.sv | 15 +
 rtl/onehot_dec.sv | 15 +
 rtl/seq_onehot_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_decoder_pkg.sv
// Shared types and constants for the sequential one-hot decoder.
package seq_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int CNT_W = 16;

endpackage : seq_decoder_pkg

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decoder used on the direct decode path.
module onehot_dec #(
   parameter int IN_W = 3
) (
   input  logic [IN_W-1:0]      in_code,
   output logic [(1<<IN_W)-1:0] onehot
);

   always_comb begin
      // NOTE: the all-zero default comes first so no latch is inferred.
      onehot          = '0;
      onehot[in_code] = 1'b1;
   end

endmodule : onehot_dec

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot decoder with a direct mode and a self-test scan mode.
// Define SEQ_DECODER_CNT_EN to add the saturating dec_count output.
module seq_onehot_decoder
   import seq_decoder_pkg::*;
#(
   parameter int IN_W      = 3,
   parameter int SCAN_HOLD = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  in_valid,
   input  logic [IN_W-1:0]       in_code,
   output logic [(1<<IN_W)-1:0]  out_q,
   output logic [IN_W-1:0]       out_code,
   output logic                  out_valid,
   output logic                  scan_busy,
   output logic                  scan_done
`ifdef SEQ_DECODER_CNT_EN
   ,
   output logic [CNT_W-1:0]      dec_count
`endif
);

   localparam int OUT_W  = 1 << IN_W;
   localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
   localparam logic [IN_W-1:0]   CODE_LAST = IN_W'(OUT_W - 1);

   if (IN_W < 1) begin : g_bad_in_w
      $error("seq_onehot_decoder: IN_W must be >= 1");
   end
   if (SCAN_HOLD < 1) begin : g_bad_hold
      $error("seq_onehot_decoder: SCAN_HOLD must be >= 1");
   end

   state_e              state_q;
   logic [IN_W-1:0]     code_q;
   logic [HOLD_W-1:0]   hold_q;
   logic                valid_q;
   logic                done_q;
   logic                valid_d;
   logic [OUT_W-1:0]    dec_onehot;

   onehot_dec #(.IN_W(IN_W)) u_onehot_dec (
      .in_code (in_code),
      .onehot  (dec_onehot)
   );

   // A new code lands on out_q either from a direct request or a scan step.
   always_comb begin
      valid_d = 1'b0;
      if (en) begin
         if (state_q == IDLE)
            valid_d = in_valid;
         else if (state_q == SCAN)
            valid_d = (hold_q == HOLD_LAST) && (code_q != CODE_LAST);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         code_q  <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         done_q  <= 1'b0;
         if (en) begin
            case (state_q)
               IDLE: begin
                  if (in_valid && mode == MODE_SCAN) begin
                     state_q <= SCAN;
                     out_q   <= OUT_W'(1);
                     code_q  <= '0;
                     hold_q  <= '0;
                  end else if (in_valid) begin
                     out_q  <= dec_onehot;
                     code_q <= in_code;
                  end
               end
               SCAN: begin
                  if (hold_q == HOLD_LAST) begin
                     hold_q <= '0;
                     if (code_q == CODE_LAST) begin
                        state_q <= DONE;
                        out_q   <= '0;
                        code_q  <= '0;
                        done_q  <= 1'b1;
                     end else begin
                        code_q <= code_q + 1'b1;
                        out_q  <= out_q << 1;
                     end
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign out_code  = code_q;
   assign out_valid = valid_q;
   assign scan_busy = (state_q == SCAN);
   assign scan_done = done_q;

`ifdef SEQ_DECODER_CNT_EN
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (valid_d && count_q != '1)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign dec_count = count_q;
`endif

endmodule : seq_onehot_decoder
